// File: rtl/store_dispatch.sv
// MEM-stage store router: aligns store data/byte-enables for DMEM/IMEM, queues UART TX bytes,
// holds a single pending CONV write and pulses the counter reset.
module store_dispatch #(
    parameter int          TX_DEPTH     = 8,
    parameter int          MEM_AW       = 14,
    parameter logic [31:0] UART_TX_ADDR = 32'h8000_0008,
    parameter logic [31:0] CONV_WR_ADDR = 32'h8000_0040,
    parameter logic [31:0] CNT_RST_ADDR = 32'h8000_0018,
    localparam int         PW           = $clog2(TX_DEPTH),
    localparam int         LW           = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              store_valid_i,
    input  logic [2:0]        funct3_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       data_i,
    input  logic              pc30_i,
    output logic [3:0]        dmem_we_o,
    output logic [3:0]        imem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_din_o,
    output logic [7:0]        uart_tx_data_o,
    output logic              uart_tx_valid_o,
    input  logic              uart_tx_ready_i,
    output logic [LW-1:0]     tx_level_o,
    output logic              conv_wr_valid_o,
    output logic [31:0]       conv_wr_data_o,
    input  logic              conv_wr_ready_i,
    output logic              counter_rst_o,
    output logic              misaligned_o,
    output logic              stall_o
);

    logic [7:0]    fifo_q [TX_DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [LW-1:0] level_q, level_d;
    logic          conv_vld_q, conv_vld_d;
    logic [31:0]   conv_dat_q, conv_dat_d;
    logic          cnt_rst_q;

    logic       is_sb, is_sh, is_sw, ok;
    logic [3:0] lane;
    logic       mmio, uart_hit, conv_hit, cnt_hit, fifo_full, push, pop;

    always_comb begin
        is_sb        = funct3_i == 3'b000;
        is_sh        = funct3_i == 3'b001;
        is_sw        = funct3_i == 3'b010;
        misaligned_o = store_valid_i & ((is_sh & addr_i[0]) | (is_sw & (addr_i[1:0] != 2'b00)));
        ok           = store_valid_i & ~misaligned_o & (is_sb | is_sh | is_sw);
        lane         = 4'b0000;
        mem_din_o    = 32'h0;
        if (store_valid_i) begin
            if (is_sb) begin
                lane      = 4'b0001 << addr_i[1:0];
                mem_din_o = {4{data_i[7:0]}};
            end else if (is_sh) begin
                lane      = 4'b0011 << {addr_i[1], 1'b0};
                mem_din_o = {2{data_i[15:0]}};
            end else if (is_sw) begin
                lane      = 4'b1111;
                mem_din_o = data_i;
            end
        end
        mem_addr_o = store_valid_i ? addr_i[MEM_AW+1:2] : '0;
        // Region 0011 aliases DMEM and, only while running from BIOS, IMEM as well.
        dmem_we_o  = (ok && (addr_i[31:28] == 4'h1 || addr_i[31:28] == 4'h3)) ? lane : 4'b0000;
        imem_we_o  = (ok && pc30_i && (addr_i[31:28] == 4'h2 || addr_i[31:28] == 4'h3))
                   ? lane : 4'b0000;
        mmio       = ok && addr_i[31:28] == 4'h8;
        uart_hit   = mmio && addr_i == UART_TX_ADDR && (is_sb || is_sw);
        conv_hit   = mmio && addr_i == CONV_WR_ADDR;
        cnt_hit    = mmio && addr_i == CNT_RST_ADDR;
        fifo_full  = level_q == LW'(TX_DEPTH);
        // A full FIFO refuses the push even if the head pops this cycle.
        stall_o    = (uart_hit && fifo_full) || (conv_hit && conv_vld_q);
        push       = uart_hit && !fifo_full;
        pop        = uart_tx_valid_o && uart_tx_ready_i;
        level_d    = level_q + LW'(push) - LW'(pop);
        conv_vld_d = conv_vld_q && !conv_wr_ready_i;
        conv_dat_d = conv_dat_q;
        if (conv_hit && !conv_vld_q) begin
            conv_vld_d = 1'b1;
            conv_dat_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q       <= '0;
            wr_q       <= '0;
            level_q    <= '0;
            conv_vld_q <= 1'b0;
            conv_dat_q <= 32'h0;
            cnt_rst_q  <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            level_q    <= level_d;
            conv_vld_q <= conv_vld_d;
            conv_dat_q <= conv_dat_d;
            cnt_rst_q  <= cnt_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_q] <= data_i[7:0];
    end

    assign uart_tx_data_o  = fifo_q[rd_q];
    assign uart_tx_valid_o = level_q != '0;
    assign tx_level_o      = level_q;
    assign conv_wr_valid_o = conv_vld_q;
    assign conv_wr_data_o  = conv_dat_q;
    assign counter_rst_o   = cnt_rst_q;

endmodule

// File: tb/tb_store_dispatch.sv
// Bench for store_dispatch: queue/flag model checked every cycle plus directed literal checks.
module tb_store_dispatch;
    localparam int          TX_DEPTH = 8;
    localparam int          MEM_AW   = 14;
    localparam logic [31:0] UART     = 32'h8000_0008;
    localparam logic [31:0] CONV     = 32'h8000_0040;
    localparam logic [31:0] CNT      = 32'h8000_0018;
    localparam int          LW       = $clog2(TX_DEPTH) + 1;

    logic clk = 1'b0, rst_n = 1'b1;
    logic sv = 1'b0, pc30 = 1'b0, tx_rdy = 1'b0, cv_rdy = 1'b0;
    logic [2:0]  f3 = 3'b0;
    logic [31:0] addr = 32'h0, data = 32'h0;
    logic [3:0]  dmem_we, imem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0] mem_din, conv_data;
    logic [7:0]  tx_data;
    logic        tx_valid, conv_valid, cnt_rst, mis, stall;
    logic [LW-1:0] tx_level;

    int checks = 0, failures = 0;

    store_dispatch #(.TX_DEPTH(TX_DEPTH), .MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst_n(rst_n), .store_valid_i(sv), .funct3_i(f3), .addr_i(addr),
        .data_i(data), .pc30_i(pc30), .dmem_we_o(dmem_we), .imem_we_o(imem_we),
        .mem_addr_o(mem_addr), .mem_din_o(mem_din), .uart_tx_data_o(tx_data),
        .uart_tx_valid_o(tx_valid), .uart_tx_ready_i(tx_rdy), .tx_level_o(tx_level),
        .conv_wr_valid_o(conv_valid), .conv_wr_data_o(conv_data), .conv_wr_ready_i(cv_rdy),
        .counter_rst_o(cnt_rst), .misaligned_o(mis), .stall_o(stall));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic ok, mis, uart, conv, cnt;
        logic [3:0] dwe, iwe;
        logic [31:0] din;
    } dec_t;

    function automatic dec_t dec(logic v, logic [2:0] fn, logic [31:0] a, logic [31:0] d, logic pc);
        dec_t r;
        int sz, lo;
        logic [3:0] ln;
        r = '0;
        if (!v) return r;
        case (fn)
            3'd0: sz = 1;
            3'd1: sz = 2;
            3'd2: sz = 4;
            default: sz = 0;
        endcase
        if (sz == 0) return r;
        lo = int'(a[1:0]);
        if (lo % sz != 0) begin
            r.mis = 1'b1;
            return r;
        end
        r.ok = 1'b1;
        for (int b = 0; b < 4; b++) begin
            ln[b] = (b >= lo) && (b < lo + sz);
            r.din[b*8 +: 8] = d[(b % sz)*8 +: 8];
        end
        case (a[31:28])
            4'h1: r.dwe = ln;
            4'h2: r.iwe = pc ? ln : 4'b0;
            4'h3: begin r.dwe = ln; r.iwe = pc ? ln : 4'b0; end
            default: ;
        endcase
        r.uart = (a == UART) && (sz != 2);
        r.conv = (a == CONV);
        r.cnt  = (a == CNT);
        return r;
    endfunction

    logic [7:0]  q[$];
    logic        cpend = 1'b0, cnt_exp = 1'b0;
    logic [31:0] cdata = 32'h0;

    function automatic logic exp_stall(dec_t e);
        return (e.uart && q.size() == TX_DEPTH) || (e.conv && cpend);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cpend   = 1'b0;
            cdata   = 32'h0;
            cnt_exp = 1'b0;
        end else begin
            dec_t e;
            logic st;
            e  = dec(sv, f3, addr, data, pc30);
            st = exp_stall(e);
            if (q.size() > 0 && tx_rdy) void'(q.pop_front());
            if (e.uart && !st) q.push_back(data[7:0]);
            if (cpend && cv_rdy) cpend = 1'b0;
            else if (e.conv && !st) begin cpend = 1'b1; cdata = data; end
            cnt_exp = e.cnt;
        end
    end

    always @(negedge clk) begin
        dec_t e;
        e = dec(sv, f3, addr, data, pc30);
        chk("dmem_we", 32'(dmem_we), 32'(e.dwe));
        chk("imem_we", 32'(imem_we), 32'(e.iwe));
        chk("misaligned", 32'(mis), 32'(e.mis));
        chk("stall", 32'(stall), 32'(exp_stall(e)));
        if (e.ok) begin
            chk("mem_din", mem_din, e.din);
            chk("mem_addr", 32'(mem_addr), (addr >> 2) & ((32'd1 << MEM_AW) - 1));
        end
        chk("tx_level", 32'(tx_level), 32'(q.size()));
        chk("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("tx_data", 32'(tx_data), 32'(q[0]));
        chk("conv_valid", 32'(conv_valid), 32'(cpend));
        if (cpend) chk("conv_data", conv_data, cdata);
        chk("counter_rst", 32'(cnt_rst), 32'(cnt_exp));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] d, input logic pc);
        sv = 1'b1; f3 = fn; addr = a; data = d; pc30 = pc;
    endtask

    task automatic idle;
        sv = 1'b0; f3 = 3'b0; addr = 32'h0; data = 32'h0; pc30 = 1'b0;
    endtask

    logic [7:0] got[$];

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_conv_valid", 32'(conv_valid), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        #1 rst_n = 1'b1;
        tick;

        st(3'd0, 32'h1000_0006, 32'h0000_00A5, 1'b0); @(negedge clk);
        chk("sb_dmem_we", 32'(dmem_we), 32'h4);
        chk("sb_din", mem_din, 32'hA5A5_A5A5);
        chk("sb_addr", 32'(mem_addr), 32'h1);
        tick;
        st(3'd2, 32'h2000_0004, 32'h1122_3344, 1'b0); @(negedge clk);
        chk("imem_nobios", 32'(imem_we), 32'h0);
        tick;
        st(3'd2, 32'h2000_0004, 32'h1122_3344, 1'b1); @(negedge clk);
        chk("imem_bios", 32'(imem_we), 32'hF);
        tick;
        st(3'd1, 32'h3000_0002, 32'h0000_BEEF, 1'b1); @(negedge clk);
        chk("sh_alias_dmem", 32'(dmem_we), 32'hC);
        chk("sh_alias_imem", 32'(imem_we), 32'hC);
        chk("sh_din", mem_din, 32'hBEEF_BEEF);
        tick;
        st(3'd1, 32'h1000_0003, 32'h0000_1234, 1'b0); @(negedge clk);
        chk("mis_flag", 32'(mis), 32'h1);
        chk("mis_we", 32'(dmem_we), 32'h0);
        tick;
        st(3'd2, 32'h4000_0000, 32'hFFFF_FFFF, 1'b1); @(negedge clk);
        chk("bios_ro", 32'({dmem_we, imem_we}), 32'h0);
        tick;
        st(3'd3, 32'h1000_0000, 32'hFFFF_FFFF, 1'b0); @(negedge clk);
        chk("bad_funct3", 32'(dmem_we), 32'h0);
        tick;

        // UART FIFO fill, overflow stall, single-cycle pop, drain order
        tx_rdy = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            st(3'd0, UART, 32'(i), 1'b0);
            tick;
        end
        st(3'd0, UART, 32'd9, 1'b0); @(negedge clk);
        chk("fifo_full_stall", 32'(stall), 32'h1);
        chk("fifo_full_level", 32'(tx_level), 32'h8);
        tick;
        tx_rdy = 1'b1; @(negedge clk);
        chk("no_bypass_stall", 32'(stall), 32'h1);
        chk("head_byte", 32'(tx_data), 32'h1);
        tick;
        tx_rdy = 1'b0; @(negedge clk);
        chk("space_free_stall", 32'(stall), 32'h0);
        chk("after_pop_level", 32'(tx_level), 32'h7);
        tick;
        idle; @(negedge clk);
        chk("refill_level", 32'(tx_level), 32'h8);
        tick;
        tx_rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (tx_valid) got.push_back(tx_data);
            tick;
        end
        tx_rdy = 1'b0;
        chk("drain_count", 32'(got.size()), 32'd8);
        for (int k = 0; k < got.size(); k++) chk("drain_order", 32'(got[k]), 32'(k + 2));

        // CONV single-entry handshake
        cv_rdy = 1'b0;
        st(3'd2, CONV, 32'h0000_1234, 1'b0); tick;
        st(3'd2, CONV, 32'h0000_5678, 1'b0); @(negedge clk);
        chk("conv_valid_held", 32'(conv_valid), 32'h1);
        chk("conv_data1", conv_data, 32'h0000_1234);
        chk("conv_pend_stall", 32'(stall), 32'h1);
        tick;
        cv_rdy = 1'b1; @(negedge clk);
        chk("conv_rdy_stall", 32'(stall), 32'h1);
        tick;
        cv_rdy = 1'b0; @(negedge clk);
        chk("conv_accept", 32'(stall), 32'h0);
        chk("conv_cleared", 32'(conv_valid), 32'h0);
        tick;
        idle; @(negedge clk);
        chk("conv_valid2", 32'(conv_valid), 32'h1);
        chk("conv_data2", conv_data, 32'h0000_5678);
        cv_rdy = 1'b1; tick;
        cv_rdy = 1'b0;

        // counter reset pulses, back to back
        st(3'd2, CNT, 32'h0, 1'b0); @(negedge clk);
        chk("cnt_same_cycle", 32'(cnt_rst), 32'h0);
        tick;
        @(negedge clk);
        chk("cnt_pulse1", 32'(cnt_rst), 32'h1);
        tick;
        idle; @(negedge clk);
        chk("cnt_pulse2", 32'(cnt_rst), 32'h1);
        tick;
        @(negedge clk);
        chk("cnt_low", 32'(cnt_rst), 32'h0);
        tick;

        // asynchronous reset with buffered state
        for (int i = 0; i < 3; i++) begin
            st(3'd2, UART, 32'h50 + 32'(i), 1'b0);
            tick;
        end
        st(3'd2, CONV, 32'hCAFE_0001, 1'b0); tick;
        idle; @(negedge clk);
        chk("pre_rst_level", 32'(tx_level), 32'h3);
        chk("pre_rst_conv", 32'(conv_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(tx_level), 32'h0);
        chk("arst_tx_valid", 32'(tx_valid), 32'h0);
        chk("arst_conv", 32'(conv_valid), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick;
        @(negedge clk);
        chk("post_rst_level", 32'(tx_level), 32'h0);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
